multi_cycle_control: RTL and testbench

Main sequencing FSM for the multi-cycle MIPS core. Decodes the instruction opcode and steps the shared datapath through fetch, decode, execute, memory and write-back, one step per state. It drives the 3-bit ALU operation code consumed by the ALU decoder, plus all mux selects and write strobes. Memory accesses wait on a ready handshake and are bounded by a timeout.

---
 rtl/multi_cycle_control_pkg.sv | 71 +++++++
 rtl/multi_cycle_control_if.sv | 35 +++
 rtl/multi_cycle_control_mem_wait_timer.sv | 26 ++
 rtl/multi_cycle_control.sv | 129 ++++++++++++
 tb/tb_multi_cycle_control.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, ALU op codes,
// mux select values and the FSM state encoding.
package multicycle_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_FUNCT = 3'b111;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_BRANCH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_WB_R     = 4'd8,
        S_EXEC_I   = 4'd9,
        S_WB_I     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    // Instruction class dispatch taken when leaving DECODE.
    function automatic state_t decode_state(input logic [5:0] opcode);
        state_t result;
        case (opcode)
            OP_LW, OP_SW:            result = S_MEM_ADDR;
            OP_RTYPE:                result = S_EXEC_R;
            OP_ADDI, OP_ORI, OP_LUI: result = S_EXEC_I;
            OP_BEQ, OP_BNE:          result = S_BRANCH;
            OP_J:                    result = S_JUMP;
            default:                 result = S_ILLEGAL;
        endcase
        return result;
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [5:0] opcode);
        logic [2:0] result;
        case (opcode)
            OP_ORI:  result = ALU_OR;
            OP_LUI:  result = ALU_LUI;
            default: result = ALU_ADD;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Control bundle between the sequencer (master) and the shared datapath (slave).
interface multi_cycle_control_if;
    logic [5:0] opcode_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       pc_write_o;
    logic       i_or_d_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       reg_write_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_op_o;
    logic [1:0] pc_source_o;
    logic       illegal_o;
    logic       fault_o;
    logic [3:0] state_o;

    modport master (
        input  opcode_i, zero_i, mem_ready_i,
        output pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
               reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, pc_source_o, illegal_o, fault_o, state_o
    );

    modport slave (
        output opcode_i, zero_i, mem_ready_i,
        input  pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
               reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, pc_source_o, illegal_o, fault_o, state_o
    );
endinterface

// File: rtl/multi_cycle_control_mem_wait_timer.sv
// Counts memory wait cycles; expired is high once the count reaches MEM_WAIT_MAX.
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    logic [CW-1:0] wait_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_count <= '0;
        end else if (clear) begin
            wait_count <= '0;
        end else if (count) begin
            wait_count <= wait_count + CW'(1);
        end
    end

    assign expired = (wait_count == CW'(MEM_WAIT_MAX));
endmodule

// File: rtl/multi_cycle_control.sv
// Main sequencing FSM of the multi-cycle MIPS core: one datapath step per state,
// with ready-handshaked memory accesses bounded by a wait timeout.
module multi_cycle_control
    import multicycle_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input logic                  clk,
    input logic                  reset,
    multi_cycle_control_if.master bus
);
    state_t state, next_state;
    logic   in_wait, waiting, expired, timeout;

    assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign waiting = in_wait && !bus.mem_ready_i;
    // Ready wins over expiry, so a timeout only fires on a cycle without ready.
    assign timeout = waiting && expired;

    mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!waiting || expired),
        .count   (waiting),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_RST;
        else       state <= next_state;
    end

    always_comb begin
        next_state       = state;
        bus.pc_write_o   = 1'b0;
        bus.i_or_d_o     = 1'b0;
        bus.mem_read_o   = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.ir_write_o   = 1'b0;
        bus.reg_dst_o    = 1'b0;
        bus.mem_to_reg_o = 1'b0;
        bus.reg_write_o  = 1'b0;
        bus.alu_src_a_o  = 1'b0;
        bus.alu_src_b_o  = SRC_B_REG;
        bus.alu_op_o     = 3'b000;
        bus.pc_source_o  = PC_SRC_ALU;
        bus.illegal_o    = 1'b0;
        bus.fault_o      = timeout;
        case (state)
            S_RST: next_state = S_FETCH;
            S_FETCH: begin
                bus.mem_read_o  = !timeout;
                bus.alu_src_b_o = SRC_B_FOUR;
                bus.alu_op_o    = ALU_ADD;
                if (bus.mem_ready_i) begin
                    bus.ir_write_o = 1'b1;
                    bus.pc_write_o = 1'b1;
                    next_state     = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.alu_src_b_o = SRC_B_BRANCH;
                bus.alu_op_o    = ALU_ADD;
                next_state      = decode_state(bus.opcode_i);
            end
            S_MEM_ADDR: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_src_b_o = SRC_B_IMM;
                bus.alu_op_o    = ALU_ADD;
                next_state      = (bus.opcode_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                bus.i_or_d_o   = 1'b1;
                bus.mem_read_o = !timeout;
                if (bus.mem_ready_i) next_state = S_MEM_WB;
                else if (timeout)    next_state = S_FETCH;
            end
            S_MEM_WR: begin
                bus.i_or_d_o    = 1'b1;
                bus.mem_write_o = !timeout;
                if (bus.mem_ready_i || timeout) next_state = S_FETCH;
            end
            S_MEM_WB: begin
                bus.mem_to_reg_o = 1'b1;
                bus.reg_write_o  = 1'b1;
                next_state       = S_FETCH;
            end
            S_EXEC_R: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_op_o    = ALU_FUNCT;
                next_state      = S_WB_R;
            end
            S_WB_R: begin
                bus.reg_dst_o   = 1'b1;
                bus.reg_write_o = 1'b1;
                next_state      = S_FETCH;
            end
            S_EXEC_I: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_src_b_o = SRC_B_IMM;
                bus.alu_op_o    = imm_alu_op(bus.opcode_i);
                next_state      = S_WB_I;
            end
            S_WB_I: begin
                bus.reg_write_o = 1'b1;
                next_state      = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_op_o    = ALU_SUB;
                bus.pc_source_o = PC_SRC_ALUOUT;
                bus.pc_write_o  = (bus.opcode_i == OP_BNE) ? !bus.zero_i : bus.zero_i;
                next_state      = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_source_o = PC_SRC_JUMP;
                bus.pc_write_o  = 1'b1;
                next_state      = S_FETCH;
            end
            S_ILLEGAL: begin
                bus.illegal_o = 1'b1;
                next_state    = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    assign bus.state_o = state;
endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: per-cycle expected outputs are queued
// as stimulus is driven and compared on the following falling edge.
module tb_multi_cycle_control;
    import multicycle_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal, fault;
    } outs_t;

    typedef struct {
        string tag;
        outs_t o;
    } item_t;

    logic  clk = 1'b0;
    logic  reset;
    int    checks = 0;
    int    errors = 0;
    item_t exp_q[$];

    multi_cycle_control_if bus();

    multi_cycle_control #(.MEM_WAIT_MAX(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic outs_t e_base(input logic [3:0] st);
        outs_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    function automatic outs_t e_fetch(input logic rdy, input logic flt);
        outs_t o = e_base(S_FETCH);
        o.mem_read = !flt; o.src_b = 2'b01; o.alu_op = 3'b100;
        o.ir_write = rdy;  o.pc_write = rdy; o.fault = flt;
        return o;
    endfunction

    function automatic outs_t e_decode();
        outs_t o = e_base(S_DECODE);
        o.src_b = 2'b11; o.alu_op = 3'b100;
        return o;
    endfunction

    function automatic outs_t e_mem_addr();
        outs_t o = e_base(S_MEM_ADDR);
        o.alu_src_a = 1'b1; o.src_b = 2'b10; o.alu_op = 3'b100;
        return o;
    endfunction

    function automatic outs_t e_mem(input logic wr, input logic flt);
        outs_t o = e_base(wr ? S_MEM_WR : S_MEM_RD);
        o.i_or_d = 1'b1; o.fault = flt;
        if (wr) o.mem_write = !flt;
        else    o.mem_read  = !flt;
        return o;
    endfunction

    function automatic outs_t e_simple(input logic [3:0] st);
        outs_t o = e_base(st);
        case (st)
            S_MEM_WB: begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
            S_EXEC_R: begin o.alu_src_a = 1'b1; o.alu_op = 3'b111; end
            S_WB_R:   begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
            S_WB_I:   o.reg_write = 1'b1;
            S_JUMP:   begin o.pc_src = 2'b10; o.pc_write = 1'b1; end
            S_ILLEGAL: o.illegal = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t e_exec_i(input logic [2:0] op);
        outs_t o = e_base(S_EXEC_I);
        o.alu_src_a = 1'b1; o.src_b = 2'b10; o.alu_op = op;
        return o;
    endfunction

    function automatic outs_t e_branch(input logic pcw);
        outs_t o = e_base(S_BRANCH);
        o.alu_src_a = 1'b1; o.alu_op = 3'b011; o.pc_src = 2'b01; o.pc_write = pcw;
        return o;
    endfunction

    task automatic push_exp(input string tag, input outs_t o);
        item_t it;
        it.tag = tag;
        it.o   = o;
        exp_q.push_back(it);
    endtask

    task automatic apply_stimulus(input string tag, input logic [5:0] op, input logic rdy,
                                  input logic z, input outs_t o);
        @(posedge clk);
        #1;
        bus.opcode_i    = op;
        bus.mem_ready_i = rdy;
        bus.zero_i      = z;
        push_exp(tag, o);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            item_t it;
            outs_t act;
            it = exp_q.pop_front();
            act = {bus.state_o, bus.pc_write_o, bus.i_or_d_o, bus.mem_read_o, bus.mem_write_o,
                   bus.ir_write_o, bus.reg_dst_o, bus.mem_to_reg_o, bus.reg_write_o,
                   bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.pc_source_o,
                   bus.illegal_o, bus.fault_o};
            check_output({it.tag, ".state"}, 32'(act.st), 32'(it.o.st));
            act.st  = '0;
            it.o.st = '0;
            check_output({it.tag, ".outs"}, 32'(act), 32'(it.o));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        reset           = 1'b1;
        bus.opcode_i    = 6'b0;
        bus.zero_i      = 1'b0;
        bus.mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            push_exp("reset", e_base(S_RST));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_exp("release", e_base(S_RST));

        // R-type add with immediate ready; ready in DECODE must be ignored.
        apply_stimulus("r.fetch",  OP_RTYPE, 1, 0, e_fetch(1, 0));
        apply_stimulus("r.decode", OP_RTYPE, 1, 0, e_decode());
        apply_stimulus("r.exec",   OP_RTYPE, 0, 0, e_simple(S_EXEC_R));
        apply_stimulus("r.wb",     OP_RTYPE, 1, 0, e_simple(S_WB_R));

        // lw with two wait cycles in MEM_RD.
        apply_stimulus("lw.fetch", OP_LW, 1, 0, e_fetch(1, 0));
        apply_stimulus("lw.decode", OP_LW, 0, 0, e_decode());
        apply_stimulus("lw.addr",  OP_LW, 0, 0, e_mem_addr());
        apply_stimulus("lw.rd0",   OP_LW, 0, 0, e_mem(0, 0));
        apply_stimulus("lw.rd1",   OP_LW, 0, 0, e_mem(0, 0));
        apply_stimulus("lw.rd2",   OP_LW, 1, 0, e_mem(0, 0));
        apply_stimulus("lw.wb",    OP_LW, 0, 0, e_simple(S_MEM_WB));

        // Branches: beq/bne with both zero values.
        for (int b = 0; b < 4; b++) begin
            logic [5:0] op;
            logic       z;
            op = (b < 2) ? OP_BEQ : OP_BNE;
            z  = b[0];
            apply_stimulus("br.fetch",  op, 1, z, e_fetch(1, 0));
            apply_stimulus("br.decode", op, 0, z, e_decode());
            apply_stimulus($sformatf("br%0d.branch", b), op, 0, z,
                           e_branch((b < 2) ? z : !z));
        end

        // Jump and immediate-ALU instructions.
        apply_stimulus("j.fetch",  OP_J, 1, 0, e_fetch(1, 0));
        apply_stimulus("j.decode", OP_J, 0, 0, e_decode());
        apply_stimulus("j.jump",   OP_J, 1, 0, e_simple(S_JUMP));
        for (int k = 0; k < 3; k++) begin
            logic [5:0] op;
            logic [2:0] aop;
            op  = (k == 0) ? OP_ADDI : (k == 1) ? OP_ORI : OP_LUI;
            aop = (k == 0) ? 3'b100  : (k == 1) ? 3'b101 : 3'b110;
            apply_stimulus("i.fetch",  op, 1, 0, e_fetch(1, 0));
            apply_stimulus("i.decode", op, 0, 0, e_decode());
            apply_stimulus($sformatf("i%0d.exec", k), op, 0, 0, e_exec_i(aop));
            apply_stimulus("i.wb",     op, 0, 0, e_simple(S_WB_I));
        end

        // Unsupported opcode.
        apply_stimulus("ill.fetch",  6'b111111, 1, 0, e_fetch(1, 0));
        apply_stimulus("ill.decode", 6'b111111, 0, 0, e_decode());
        apply_stimulus("ill.pulse",  6'b111111, 0, 0, e_simple(S_ILLEGAL));

        // sw with ready stuck low: fault on 4th MEM_WR cycle, then FETCH.
        apply_stimulus("swto.fetch",  OP_SW, 1, 0, e_fetch(1, 0));
        apply_stimulus("swto.decode", OP_SW, 0, 0, e_decode());
        apply_stimulus("swto.addr",   OP_SW, 0, 0, e_mem_addr());
        for (int w = 0; w < 3; w++) apply_stimulus("swto.wait", OP_SW, 0, 0, e_mem(1, 0));
        apply_stimulus("swto.fault",  OP_SW, 0, 0, e_mem(1, 1));

        // sw with ready arriving exactly at expiry: normal completion.
        apply_stimulus("swrdy.fetch",  OP_SW, 1, 0, e_fetch(1, 0));
        apply_stimulus("swrdy.decode", OP_SW, 0, 0, e_decode());
        apply_stimulus("swrdy.addr",   OP_SW, 0, 0, e_mem_addr());
        for (int w = 0; w < 3; w++) apply_stimulus("swrdy.wait", OP_SW, 0, 0, e_mem(1, 0));
        apply_stimulus("swrdy.done",   OP_SW, 1, 0, e_mem(1, 0));

        // lw aborted in MEM_RD: no write-back, straight to FETCH.
        apply_stimulus("lwto.fetch",  OP_LW, 1, 0, e_fetch(1, 0));
        apply_stimulus("lwto.decode", OP_LW, 0, 0, e_decode());
        apply_stimulus("lwto.addr",   OP_LW, 0, 0, e_mem_addr());
        for (int w = 0; w < 3; w++) apply_stimulus("lwto.wait", OP_LW, 0, 0, e_mem(0, 0));
        apply_stimulus("lwto.fault",  OP_LW, 0, 0, e_mem(0, 1));

        // FETCH timeout retries in FETCH with a fresh wait count.
        for (int w = 0; w < 3; w++) apply_stimulus("fto.wait", OP_RTYPE, 0, 0, e_fetch(0, 0));
        apply_stimulus("fto.fault", OP_RTYPE, 0, 0, e_fetch(0, 1));
        for (int w = 0; w < 3; w++) apply_stimulus("fto.retry", OP_RTYPE, 0, 0, e_fetch(0, 0));
        apply_stimulus("fto.done",   OP_RTYPE, 1, 0, e_fetch(1, 0));
        apply_stimulus("fto.decode", OP_RTYPE, 0, 0, e_decode());
        apply_stimulus("mid.exec",   OP_RTYPE, 0, 0, e_simple(S_EXEC_R));

        // Reset mid-instruction drops the pending WB_R.
        @(posedge clk);
        #1;
        reset = 1'b1;
        push_exp("mid.reset", e_base(S_RST));
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_exp("mid.release", e_base(S_RST));
        apply_stimulus("post.fetch",  OP_ADDI, 1, 0, e_fetch(1, 0));
        apply_stimulus("post.decode", OP_ADDI, 0, 0, e_decode());
        apply_stimulus("post.exec",   OP_ADDI, 0, 0, e_exec_i(3'b100));
        apply_stimulus("post.wb",     OP_ADDI, 0, 0, e_simple(S_WB_I));

        repeat (3) @(negedge clk);
        check_output("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
